// File: rtl/uart_pkg.sv
// Shared UART constants: data width, default RX FIFO sizing and the occupancy
// width helper also used by the peripheral register file.
package uart_pkg;

   localparam int UART_DATA_W          = 8;
   localparam int UART_RX_FIFO_DEPTH   = 16;
   localparam int UART_RX_FIFO_THRESH  = 8;

   // Occupancy counters need one extra bit so that "full" (== depth) is representable.
   function automatic int uart_occ_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DATA_W storage for the RX FIFO: synchronous write, asynchronous read, no reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_RX_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = UART_DATA_W
) (
   input  logic              i_Clock,
   input  logic              i_Wr_En,
   input  logic [ADDR_W-1:0] i_Wr_Addr,
   input  logic [DATA_W-1:0] i_Wr_Data,
   input  logic [ADDR_W-1:0] i_Rd_Addr,
   output logic [DATA_W-1:0] o_Rd_Data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge i_Clock) begin
      if (i_Wr_En) begin
         mem[i_Wr_Addr] <= i_Wr_Data;
      end
   end

   assign o_Rd_Data = mem[i_Rd_Addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver, with sticky overflow.
// Define UART_RX_FIFO_IRQ_EN to build the occupancy-threshold interrupt (o_Irq).
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_RX_FIFO_DEPTH,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int THRESH = UART_RX_FIFO_THRESH
) (
   input  logic                   i_Clock,
   input  logic                   i_Rst_n,
   input  logic                   i_RX_DV,
   input  logic [UART_DATA_W-1:0] i_RX_Byte,
   input  logic                   i_Rd_En,
   output logic [UART_DATA_W-1:0] o_Rd_Data,
   output logic                   o_Empty,
   output logic                   o_Full,
   output logic [ADDR_W:0]        o_Count,
   output logic                   o_Overflow,
   input  logic                   i_Clr_Ovf,
   output logic                   o_Irq
);

   localparam int CNT_W = uart_occ_width(DEPTH);

   generate
      if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
         $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
      end
      if (ADDR_W != $clog2(DEPTH) || CNT_W != ADDR_W + 1) begin : g_addr_chk
         $error("uart_rx_fifo: ADDR_W is derived from DEPTH and must not be overridden");
      end
   endgenerate

   logic [ADDR_W-1:0]      wr_ptr;
   logic [ADDR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]       count;
   logic                   overflow;
   logic                   empty;
   logic                   full;
   logic                   push;
   logic                   pop;
   logic                   drop;
   logic [UART_DATA_W-1:0] mem_rd_data;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // A pop frees a slot in the same edge, so a full FIFO still accepts a byte alongside a pop.
   assign push = i_RX_DV & (~full | i_Rd_En);
   assign pop  = i_Rd_En & ~empty;
   assign drop = i_RX_DV & full & ~i_Rd_En;

   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end else if (i_Clr_Ovf) begin
            overflow <= 1'b0;
         end
      end
   end

   uart_fifo_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (UART_DATA_W)
   ) u_mem (
      .i_Clock   (i_Clock),
      .i_Wr_En   (push & i_Rst_n),
      .i_Wr_Addr (wr_ptr),
      .i_Wr_Data (i_RX_Byte),
      .i_Rd_Addr (rd_ptr),
      .o_Rd_Data (mem_rd_data)
   );

   assign o_Rd_Data  = empty ? '0 : mem_rd_data;
   assign o_Empty    = empty;
   assign o_Full     = full;
   assign o_Count    = count;
   assign o_Overflow = overflow;

`ifdef UART_RX_FIFO_IRQ_EN
   generate
      if (THRESH < 1 || THRESH > DEPTH) begin : g_thresh_chk
         $error("uart_rx_fifo: THRESH must lie in 1..DEPTH");
      end
   endgenerate

   logic irq_q;

   // Registered from the count register, so the interrupt trails occupancy by one edge.
   always_ff @(posedge i_Clock) begin
      if (!i_Rst_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= (count >= CNT_W'(THRESH));
      end
   end

   assign o_Irq = irq_q;
`else
   generate
      if (THRESH < 0) begin : g_thresh_sign_chk
         $error("uart_rx_fifo: THRESH must be non-negative");
      end
   endgenerate

   assign o_Irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus biased random traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;
   localparam int TH    = 8;

   logic       i_Clock = 1'b0;
   logic       i_Rst_n = 1'b0;
   logic       i_RX_DV = 1'b0;
   logic [7:0] i_RX_Byte = 8'h00;
   logic       i_Rd_En = 1'b0;
   logic [7:0] o_Rd_Data;
   logic       o_Empty;
   logic       o_Full;
   logic [4:0] o_Count;
   logic       o_Overflow;
   logic       i_Clr_Ovf = 1'b0;
   logic       o_Irq;

   int checks = 0;
   int failures = 0;

   logic [7:0] q[$];
   bit         exp_ovf = 1'b0;
   bit         exp_irq = 1'b0;
   logic [7:0] exp_pop;
   logic [7:0] got_pop;
   bit         did_pop;

   uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(TH)) dut (
      .i_Clock    (i_Clock),
      .i_Rst_n    (i_Rst_n),
      .i_RX_DV    (i_RX_DV),
      .i_RX_Byte  (i_RX_Byte),
      .i_Rd_En    (i_Rd_En),
      .o_Rd_Data  (o_Rd_Data),
      .o_Empty    (o_Empty),
      .o_Full     (o_Full),
      .o_Count    (o_Count),
      .o_Overflow (o_Overflow),
      .i_Clr_Ovf  (i_Clr_Ovf),
      .o_Irq      (o_Irq)
   );

   always #5 i_Clock = ~i_Clock;

   // One clock of stimulus; the reference model advances from the queue rules, not the RTL.
   task automatic tick(input bit dv, input logic [7:0] b, input bit rd, input bit clr, input bit rst_n);
      int old_size;
      bit full_m, empty_m;
      i_RX_DV = dv; i_RX_Byte = b; i_Rd_En = rd; i_Clr_Ovf = clr; i_Rst_n = rst_n;
      #1;
      got_pop  = o_Rd_Data;
      old_size = q.size();
      full_m   = (old_size == DEPTH);
      empty_m  = (old_size == 0);
      did_pop  = rst_n && rd && !empty_m;
      exp_pop  = empty_m ? 8'h00 : q[0];
      @(posedge i_Clock); #1;
      if (!rst_n) begin
         q.delete(); exp_ovf = 1'b0; exp_irq = 1'b0;
      end else begin
         if (rd && !empty_m) void'(q.pop_front());
         if (dv && (!full_m || rd)) q.push_back(b);
         if (dv && full_m && !rd) exp_ovf = 1'b1;
         else if (clr) exp_ovf = 1'b0;
`ifdef UART_RX_FIFO_IRQ_EN
         exp_irq = (old_size >= TH);
`endif
      end
      i_RX_DV = 1'b0; i_RX_Byte = 8'h00; i_Rd_En = 1'b0; i_Clr_Ovf = 1'b0; i_Rst_n = 1'b1;
   endtask

   task automatic test_reset();
      tick(0, 8'h00, 0, 0, 0);
      tick(0, 8'h00, 0, 0, 0);
      checks++; if (o_Count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", o_Count); end
      checks++; if (o_Empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", o_Empty); end
      checks++; if (o_Full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", o_Full); end
      checks++; if (o_Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", o_Overflow); end
      checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", o_Irq); end
      checks++; if (o_Rd_Data !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", o_Rd_Data); end
   endtask

   task automatic test_single();
      tick(1, 8'hA5, 0, 0, 1);
      checks++; if (o_Empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", o_Empty); end
      checks++; if (o_Rd_Data !== 8'hA5) begin failures++; $display("FAIL single_rdata got=%h exp=a5", o_Rd_Data); end
      tick(0, 8'h00, 1, 0, 1);
      checks++; if (got_pop !== 8'hA5) begin failures++; $display("FAIL single_pop got=%h exp=a5", got_pop); end
      checks++; if (o_Empty !== 1'b1) begin failures++; $display("FAIL single_empty_after got=%b exp=1", o_Empty); end
      checks++; if (o_Rd_Data !== 8'h00) begin failures++; $display("FAIL single_rdata_after got=%h exp=00", o_Rd_Data); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DEPTH; i++) tick(1, 8'(i), 0, 0, 1);
      checks++; if (o_Full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", o_Full); end
      checks++; if (o_Count !== 5'd16) begin failures++; $display("FAIL fill_count got=%0d exp=16", o_Count); end
      for (int i = 0; i < DEPTH; i++) begin
         tick(0, 8'h00, 1, 0, 1);
         checks++; if (got_pop !== 8'(i)) begin failures++; $display("FAIL drain_order idx=%0d got=%h exp=%h", i, got_pop, 8'(i)); end
      end
      checks++; if (o_Empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", o_Empty); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < DEPTH; i++) tick(1, 8'($urandom_range(0, 8'hED)), 0, 0, 1);
      tick(1, 8'hEE, 0, 0, 1);
      checks++; if (o_Overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", o_Overflow); end
      checks++; if (o_Count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", o_Count); end
      tick(1, 8'hEE, 0, 1, 1);
      checks++; if (o_Overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins got=%b exp=1", o_Overflow); end
      tick(0, 8'h00, 0, 1, 1);
      checks++; if (o_Overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", o_Overflow); end
      for (int i = 0; i < DEPTH; i++) begin
         tick(0, 8'h00, 1, 0, 1);
         checks++; if (got_pop !== exp_pop || got_pop === 8'hEE) begin failures++; $display("FAIL ovf_drain idx=%0d got=%h exp=%h", i, got_pop, exp_pop); end
      end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < DEPTH; i++) tick(1, 8'($urandom_range(0, 8'h76)), 0, 0, 1);
      tick(1, 8'h77, 1, 0, 1);
      checks++; if (o_Overflow !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", o_Overflow); end
      checks++; if (o_Count !== 5'd16) begin failures++; $display("FAIL fpp_count got=%0d exp=16", o_Count); end
      checks++; if (got_pop !== exp_pop) begin failures++; $display("FAIL fpp_pop got=%h exp=%h", got_pop, exp_pop); end
      for (int i = 0; i < DEPTH; i++) tick(0, 8'h00, 1, 0, 1);
      checks++; if (got_pop !== 8'h77) begin failures++; $display("FAIL fpp_last got=%h exp=77", got_pop); end
      checks++; if (o_Empty !== 1'b1) begin failures++; $display("FAIL fpp_empty got=%b exp=1", o_Empty); end
   endtask

   task automatic test_empty_push_pop();
      tick(1, 8'h3C, 1, 0, 1);
      checks++; if (o_Count !== 5'd1) begin failures++; $display("FAIL epp_count got=%0d exp=1", o_Count); end
      checks++; if (o_Rd_Data !== 8'h3C) begin failures++; $display("FAIL epp_rdata got=%h exp=3c", o_Rd_Data); end
      tick(0, 8'h00, 1, 0, 1);
      checks++; if (got_pop !== 8'h3C) begin failures++; $display("FAIL epp_pop got=%h exp=3c", got_pop); end
   endtask

   task automatic test_irq();
      bit irq_on;
`ifdef UART_RX_FIFO_IRQ_EN
      irq_on = 1'b1;
`else
      irq_on = 1'b0;
`endif
      for (int i = 0; i < TH - 1; i++) tick(1, 8'($urandom), 0, 0, 1);
      tick(0, 8'h00, 0, 0, 1);
      checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL irq_below got=%b exp=0", o_Irq); end
      tick(1, 8'($urandom), 0, 0, 1);
      checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL irq_lag got=%b exp=0", o_Irq); end
      tick(0, 8'h00, 0, 0, 1);
      checks++; if (o_Irq !== irq_on) begin failures++; $display("FAIL irq_rise got=%b exp=%b", o_Irq, irq_on); end
      tick(0, 8'h00, 1, 0, 1);
      checks++; if (o_Irq !== irq_on) begin failures++; $display("FAIL irq_hold got=%b exp=%b", o_Irq, irq_on); end
      tick(0, 8'h00, 0, 0, 1);
      checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", o_Irq); end
      while (q.size() != 0) tick(0, 8'h00, 1, 0, 1);
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < 5; i++) tick(1, 8'($urandom), 0, 0, 1);
      checks++; if (o_Count !== 5'd5) begin failures++; $display("FAIL mid_pre_count got=%0d exp=5", o_Count); end
      tick(1, 8'hAA, 1, 0, 0);
      checks++; if (o_Count !== 5'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", o_Count); end
      checks++; if (o_Empty !== 1'b1) begin failures++; $display("FAIL mid_empty got=%b exp=1", o_Empty); end
      checks++; if (o_Full !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", o_Full); end
      checks++; if (o_Overflow !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b exp=0", o_Overflow); end
      checks++; if (o_Irq !== 1'b0) begin failures++; $display("FAIL mid_irq got=%b exp=0", o_Irq); end
      checks++; if (o_Rd_Data !== 8'h00) begin failures++; $display("FAIL mid_rdata got=%h exp=00", o_Rd_Data); end
   endtask

   task automatic test_random();
      logic [7:0] exp_head;
      for (int n = 0; n < 800; n++) begin
         int up;
         up = ((n / 100) % 2 == 0) ? 70 : 30;
         tick($urandom_range(0, 99) < up, 8'($urandom), $urandom_range(0, 99) < (100 - up),
              $urandom_range(0, 9) == 0, $urandom_range(0, 299) != 0);
         exp_head = (q.size() != 0) ? q[0] : 8'h00;
         checks++; if (o_Count !== 5'(q.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, o_Count, q.size()); end
         checks++; if (o_Empty !== (q.size() == 0)) begin failures++; $display("FAIL rnd_empty n=%0d got=%b", n, o_Empty); end
         checks++; if (o_Full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rnd_full n=%0d got=%b", n, o_Full); end
         checks++; if (o_Overflow !== exp_ovf) begin failures++; $display("FAIL rnd_ovf n=%0d got=%b exp=%b", n, o_Overflow, exp_ovf); end
         checks++; if (o_Irq !== exp_irq) begin failures++; $display("FAIL rnd_irq n=%0d got=%b exp=%b", n, o_Irq, exp_irq); end
         checks++; if (o_Rd_Data !== exp_head) begin failures++; $display("FAIL rnd_rdata n=%0d got=%h exp=%h", n, o_Rd_Data, exp_head); end
         if (did_pop) begin
            checks++; if (got_pop !== exp_pop) begin failures++; $display("FAIL rnd_pop n=%0d got=%h exp=%h", n, got_pop, exp_pop); end
         end
      end
   endtask

   initial begin
      @(posedge i_Clock); #1;
      test_reset();
      test_single();
      test_fill_drain();
      test_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_irq();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
